// File: rtl/cpuid_leaf_fetch_pkg.sv
// Shared capability-ROM window register map and helpers for the leaf fetch master.
package cpuid_leaf_fetch_pkg;

  localparam int CARBON_CAPROM_REG_INDEX = 0;
  localparam int CARBON_CAPROM_REG_DATA0 = 1;
  localparam int CARBON_CAPROM_REG_DATA1 = 2;
  localparam int CARBON_CAPROM_REG_DATA2 = 3;
  localparam int CARBON_CAPROM_REG_DATA3 = 4;

  localparam int CAPROM_WORDS = 4;

  function automatic int unsigned caprom_data_off(input logic [1:0] k);
    return int'(CARBON_CAPROM_REG_DATA0) + int'(k);
  endfunction

endpackage

// File: rtl/csr_if.sv
// Single-outstanding CSR request/response bus used between fabric masters and slaves.
interface csr_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/cpuid_leaf_fetch.sv
// CPUID leaf fetch: writes the ROM window INDEX, reads DATA0..DATA3, and keeps a
// one-entry cache of the last cleanly fetched leaf.
module cpuid_leaf_fetch
  import cpuid_leaf_fetch_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                TIMEOUT_CYCLES = 256,
  parameter bit                CACHE_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [31:0]       q_leaf,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_word [CAPROM_WORDS],
  output logic              r_fault,
  output logic              r_hit,
  csr_if.master             csr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WIDX, S_WRSP, S_RREQ, S_RRSP, S_FAULT, S_DONE
  } state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [1:0]        k_q;
  logic [TW-1:0]     tmo_q;
  logic              cache_vld, fill_ok;
  logic [31:0]       cache_leaf;
  logic [DATA_W-1:0] cache_word [CAPROM_WORDS];
  logic [DATA_W-1:0] leaf_q;

  logic accept, hit_now, in_wait, tmo_hit, rd_ok, fill_now;

  assign accept   = (state_q == S_IDLE) && q_valid;
  assign hit_now  = CACHE_EN && cache_vld && (q_leaf == cache_leaf) && !flush;
  assign in_wait  = (state_q == S_WRSP) || (state_q == S_RRSP);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign rd_ok    = (state_q == S_RRSP) && csr.rsp_valid && !csr.rsp_fault;
  assign fill_now = rd_ok && (k_q == 2'd3) && CACHE_EN && fill_ok && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (q_valid) state_d = hit_now ? S_DONE : S_WIDX;
      S_WIDX:  if (csr.req_ready) state_d = S_WRSP;
      S_WRSP: begin
        if (csr.rsp_valid)  state_d = csr.rsp_fault ? S_FAULT : S_RREQ;
        else if (tmo_hit)   state_d = S_FAULT;
      end
      S_RREQ:  if (csr.req_ready) state_d = S_RRSP;
      S_RRSP: begin
        if (csr.rsp_valid) begin
          if (csr.rsp_fault)      state_d = S_FAULT;
          else if (k_q == 2'd3)   state_d = S_DONE;
          else                    state_d = S_RREQ;
        end else if (tmo_hit) begin
          state_d = S_FAULT;
        end
      end
      S_FAULT: state_d = S_DONE;
      S_DONE:  if (r_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Unread words are cleared at accept so a fault leaves them at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      tmo_q     <= '0;
      cache_vld <= 1'b0;
      fill_ok   <= 1'b0;
      r_fault   <= 1'b0;
      r_hit     <= 1'b0;
      for (int i = 0; i < CAPROM_WORDS; i++) r_word[i] <= '0;
    end else begin
      tmo_q <= in_wait ? tmo_q + 1'b1 : '0;
      if (accept) begin
        k_q     <= '0;
        fill_ok <= 1'b1;
        r_fault <= 1'b0;
        r_hit   <= hit_now;
        for (int i = 0; i < CAPROM_WORDS; i++) r_word[i] <= hit_now ? cache_word[i] : '0;
      end
      if (rd_ok) begin
        r_word[k_q] <= csr.rsp_rdata;
        if (k_q != 2'd3) k_q <= k_q + 2'd1;
      end
      if (state_d == S_FAULT) begin
        r_fault <= 1'b1;
        r_hit   <= 1'b0;
      end
      if (fill_now) cache_vld <= 1'b1;
      if (flush) begin
        cache_vld <= 1'b0;
        fill_ok   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) leaf_q <= q_leaf;
    if (fill_now) begin
      cache_leaf <= leaf_q;
      for (int i = 0; i < CAPROM_WORDS - 1; i++) cache_word[i] <= r_word[i];
      cache_word[CAPROM_WORDS-1] <= csr.rsp_rdata;
    end
  end

  assign q_ready       = (state_q == S_IDLE);
  assign r_valid       = (state_q == S_DONE);
  assign csr.req_valid = (state_q == S_WIDX) || (state_q == S_RREQ);
  assign csr.req_write = (state_q == S_WIDX);
  assign csr.req_addr  = (state_q == S_WIDX)
                       ? BASE_ADDR + ADDR_W'(CARBON_CAPROM_REG_INDEX)
                       : BASE_ADDR + ADDR_W'(caprom_data_off(k_q));
  assign csr.req_wdata = (state_q == S_WIDX) ? leaf_q : '0;
  assign csr.rsp_ready = 1'b1;

endmodule
